uart_echo: RTL and testbench

// - Full-duplex 8N1 UART with no parallel host interface: every byte received on rx is retransmitted on tx.
// - Standalone serial loopback/echo endpoint for board bring-up and link checks.
// - One clock domain. rx is asynchronous to clk and is synchronised internally.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_echo_if.sv | 17 +
 rtl/uart_tx_engine.sv | 97 +++++++++
 rtl/uart_echo.sv | 142 ++++++++++++++
 tb/tb_uart_echo.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and FSM state encodings for the UART echo endpoint.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop,
    RxBreak
  } rx_state_e;

  typedef enum logic [1:0] {
    TxIdle,
    TxStart,
    TxData,
    TxStop
  } tx_state_e;

endpackage

// File: rtl/uart_echo_if.sv
// Serial line pair of the echo endpoint; the device drives tx, the far end drives rx.
interface uart_echo_if;

  logic rx;
  logic tx;

  modport dut (
    input  rx,
    output tx
  );

  modport host (
    output rx,
    input  tx
  );

endinterface

// File: rtl/uart_tx_engine.sv
// 8N1 transmitter: baud counter, shift register and TX FSM with a registered tx line.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  output logic                 busy,
  output logic                 tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] BitLast = CW'(CLKS_PER_BIT - 1);

  tx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = 1'b1;
    unique case (state_q)
      TxIdle: begin
        if (load) begin
          shift_d = data;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = TxStart;
        end
      end
      TxStart: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = TxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TxData: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = TxStop;
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          state_d = TxIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = TxIdle;
    endcase
    // Line level follows the next state so tx stays a clean flop output.
    unique case (state_d)
      TxStart: tx_d = 1'b0;
      TxData:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign busy = (state_q != TxIdle);
  assign tx   = tx_q;

endmodule

// File: rtl/uart_echo.sv
// UART echo endpoint: synchronised 8N1 receiver feeding a one-entry buffer that drives the transmitter.
module uart_echo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input logic      clk,
  input logic      reset,
  uart_echo_if.dut ser
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HalfLast = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BitLast  = CW'(CLKS_PER_BIT - 1);

  logic rx_meta_q, rx_sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= ser.rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    rx_valid = 1'b0;
    unique case (state_q)
      RxIdle: begin
        if (!rx_sync_q) begin
          cnt_d   = '0;
          state_d = RxStart;
        end
      end
      RxStart: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_sync_q ? RxIdle : RxData;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == 3'(DATA_BITS - 1)) begin
            state_d = RxStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_sync_q) begin
            rx_valid = 1'b1;
            state_d  = RxIdle;
          end else begin
            state_d = RxBreak;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RxBreak: begin
        if (rx_sync_q) state_d = RxIdle;
      end
      default: state_d = RxIdle;
    endcase
  end

  logic                 buf_full_q, buf_full_d;
  logic [DATA_BITS-1:0] buf_data_q, buf_data_d;
  logic                 tx_busy, tx_load;

  assign tx_load = buf_full_q && !tx_busy;

  always_comb begin
    buf_full_d = buf_full_q;
    buf_data_d = buf_data_q;
    if (tx_load) buf_full_d = 1'b0;
    // A byte arriving while the held byte is still waiting is dropped.
    if (rx_valid && (!buf_full_q || tx_load)) begin
      buf_full_d = 1'b1;
      buf_data_d = shift_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_full_q <= 1'b0;
      buf_data_q <= '0;
    end else begin
      buf_full_q <= buf_full_d;
      buf_data_q <= buf_data_d;
    end
  end

  uart_tx_engine #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tx (
    .clk  (clk),
    .reset(reset),
    .load (tx_load),
    .data (buf_data_q),
    .busy (tx_busy),
    .tx   (ser.tx)
  );

endmodule

// File: tb/tb_uart_echo.sv
// Self-checking bench for uart_echo: random 8N1 frames, transaction-level echo model, tx-line monitor.
module tb_uart_echo;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  uart_echo_if ser ();

  uart_echo #(
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .ser  (ser)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: a good frame completes at its stop-bit midpoint; the echo path is one
  // transmitter plus one waiting slot, and a byte finding both occupied is lost.
  logic [7:0] exp_q[$];
  int         model_pushed = 0;
  int         m_busy_until = 0;
  bit         m_buf_full   = 0;

  task automatic model_rx(input logic [7:0] b, input int t);
    if (m_buf_full && m_busy_until <= t) begin
      m_buf_full   = 0;
      m_busy_until = m_busy_until + FRAME + 1;
    end
    if (!m_buf_full) begin
      if (m_busy_until <= t + 1) m_busy_until = t + FRAME + 2;
      else m_buf_full = 1;
      exp_q.push_back(b);
      model_pushed++;
    end
  endtask

  task automatic model_reset();
    model_pushed = model_pushed - exp_q.size();
    exp_q.delete();
    m_buf_full   = 0;
    m_busy_until = 0;
  endtask

  // Monitor: decodes frames from tx at bit midpoints and scores them against the model queue.
  int         tx_low_cnt = 0;
  int         mon_frames = 0;
  bit         m_active   = 0;
  int         m_cnt      = 0;
  logic [7:0] m_byte     = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        m_active = 0;
      end else begin
        if (ser.tx === 1'b0) tx_low_cnt++;
        if (!m_active) begin
          if (ser.tx === 1'b0) begin
            m_active = 1;
            m_cnt    = 0;
          end
        end else begin
          m_cnt++;
        end
        if (m_active && (m_cnt % CPB) == CPB / 2) begin
          if (m_cnt / CPB == 0) begin
            check("start_bit", 32'(ser.tx), 32'd0);
          end else if (m_cnt / CPB <= 8) begin
            m_byte[m_cnt/CPB-1] = ser.tx;
          end else begin
            check("stop_bit", 32'(ser.tx), 32'd1);
            if (exp_q.size() == 0) begin
              check("spurious_echo", 32'(m_byte), 32'h100);
            end else begin
              check("echo_byte", 32'(m_byte), 32'(exp_q.pop_front()));
            end
            mon_frames++;
            m_active = 0;
          end
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    int s;
    s = cyc;
    ser.rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser.rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    ser.rx = stop_bit;
    repeat (CPB) @(negedge clk);
    ser.rx = 1'b1;
    if (stop_bit) model_rx(b, s + FRAME - CPB / 2 + 3);
  endtask

  task automatic idle(input int n);
    ser.rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int budget;
    budget = 6 * FRAME;
    while ((exp_q.size() != 0 || m_active) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int  low0;
    int  fr0;
    bit  seen;
    ser.rx = 1'b1;
    #1 reset = 1'b0;
    #1 check("tx_in_reset", 32'(ser.tx), 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    low0 = tx_low_cnt;
    repeat (200) @(negedge clk);
    check("idle_tx_low_clks", 32'(tx_low_cnt - low0), 32'd0);

    send_frame(8'hA5, 1'b1);
    drain();

    // One-clock low pulse must be rejected as a glitch.
    low0 = tx_low_cnt;
    @(negedge clk);
    ser.rx = 1'b0;
    @(negedge clk);
    ser.rx = 1'b1;
    idle(3 * FRAME);
    check("glitch_tx_low_clks", 32'(tx_low_cnt - low0), 32'd0);

    send_frame(8'h3C, 1'b0);
    idle(3 * CPB);
    send_frame(8'h55, 1'b1);
    drain();

    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    drain();

    for (int i = 0; i < 24; i++) begin
      logic [7:0] b;
      bit         bad;
      b   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, !bad);
      if (bad) idle(CPB + int'($urandom_range(0, 8)));
      else idle(int'($urandom_range(0, 12)));
      if ($urandom_range(0, 5) == 0) begin
        idle(2 * CPB);
        ser.rx = 1'b0;
        @(negedge clk);
        idle(2 * CPB);
      end
    end
    drain();
    check("frame_count", 32'(mon_frames), 32'(model_pushed));

    // Reset in the middle of an echo aborts it and leaves the line quiet.
    send_frame(8'h5A, 1'b1);
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ser.tx === 1'b0) seen = 1;
    end
    check("echo_5a_started", 32'(seen), 32'd1);
    repeat (6) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("tx_async_reset", 32'(ser.tx), 32'd1);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    low0 = tx_low_cnt;
    fr0  = mon_frames;
    repeat (200) @(negedge clk);
    check("post_reset_tx_low_clks", 32'(tx_low_cnt - low0), 32'd0);
    check("post_reset_frames", 32'(mon_frames - fr0), 32'd0);
    check("post_reset_tx_level", 32'(ser.tx), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
